// File: rtl/secuenciador_sel.sv
// secuenciador_sel: select sequencer feeding the 2-bit i_Sel of the 4:1 Demx.
// Steps through the channels enabled in a latched 4-bit mask. Each enabled
// channel is held for DWELL cycles. Operation is either a single sweep
// (ending with a one-cycle o_Fin pulse) or a continuous loop.
//
// Ports
//   i_Clk      clock, rising edge
//   i_Rst      asynchronous active-high reset
//   i_Inicio   start request; i_Continuo and i_Mascara are sampled with it
//   i_Continuo 1 = loop forever, 0 = single sweep
//   i_Detener  abort; returns to idle on the next cycle, no o_Fin
//   i_Mascara  channel enables, bit n = channel n
//   o_Sel      current channel (held while idle)
//   o_Valido   high on every cycle of a dwell
//   o_Cambio   pulse on the first cycle of each dwell
//   o_Ocupado  high while sweeping
//   o_Fin      pulse when a single sweep completes
module secuenciador_sel #(
  parameter int unsigned DWELL   = 50,
  parameter int unsigned DWELL_W = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Inicio,
  input  logic       i_Continuo,
  input  logic       i_Detener,
  input  logic [3:0] i_Mascara,
  output logic [1:0] o_Sel,
  output logic       o_Valido,
  output logic       o_Cambio,
  output logic       o_Ocupado,
  output logic       o_Fin
);

  typedef enum logic [1:0] {
    REPOSO,
    ESPERA,
    FIN
  } estado_t;

  localparam logic [DWELL_W-1:0] CARGA = DWELL_W'(DWELL - 1);

  estado_t            estado, estado_n;
  logic [1:0]         sel, sel_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [3:0]         mask_q, mask_n;
  logic               cont_q, cont_n;
  logic               valido, valido_n;
  logic               cambio, cambio_n;
  logic               ocupado, ocupado_n;
  logic               fin, fin_n;

  logic [1:0]         primer_in;
  logic [1:0]         primer_lat;
  logic [2:0]         siguiente_lat;

  // Lowest set bit of the mask (mask assumed non-zero by the callers).
  function automatic logic [1:0] primer(input logic [3:0] m);
    logic [1:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = 2'(i - 1);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  // {found, channel}: lowest set bit strictly above 'desde'; no wrap.
  function automatic logic [2:0] siguiente(input logic [3:0] m, input logic [1:0] desde);
    logic [2:0] r;
    logic [1:0] idx;
    r = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = 2'(i - 1);
      if (m[idx] && (idx > desde)) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign primer_in     = primer(i_Mascara);
  assign primer_lat    = primer(mask_q);
  assign siguiente_lat = siguiente(mask_q, sel);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      estado  <= REPOSO;
      sel     <= '0;
      cnt     <= '0;
      mask_q  <= '0;
      cont_q  <= 1'b0;
      valido  <= 1'b0;
      cambio  <= 1'b0;
      ocupado <= 1'b0;
      fin     <= 1'b0;
    end else begin
      estado  <= estado_n;
      sel     <= sel_n;
      cnt     <= cnt_n;
      mask_q  <= mask_n;
      cont_q  <= cont_n;
      valido  <= valido_n;
      cambio  <= cambio_n;
      ocupado <= ocupado_n;
      fin     <= fin_n;
    end
  end

  // Next-state logic also computes next output values so every output
  // comes straight from a flop.
  always_comb begin
    estado_n  = estado;
    sel_n     = sel;
    cnt_n     = cnt;
    mask_n    = mask_q;
    cont_n    = cont_q;
    valido_n  = 1'b0;
    cambio_n  = 1'b0;
    ocupado_n = 1'b0;
    fin_n     = 1'b0;

    if (i_Detener) begin
      estado_n = REPOSO;
    end else begin
      unique case (estado)
        REPOSO: begin
          if (i_Inicio && (i_Mascara != '0)) begin
            mask_n    = i_Mascara;
            cont_n    = i_Continuo;
            sel_n     = primer_in;
            cnt_n     = CARGA;
            estado_n  = ESPERA;
            valido_n  = 1'b1;
            cambio_n  = 1'b1;
            ocupado_n = 1'b1;
          end
        end
        ESPERA: begin
          valido_n  = 1'b1;
          ocupado_n = 1'b1;
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (siguiente_lat[2]) begin
            sel_n    = siguiente_lat[1:0];
            cnt_n    = CARGA;
            cambio_n = 1'b1;
          end else if (cont_q) begin
            // Wrap; with a single-bit mask this re-dwells the same channel.
            sel_n    = primer_lat;
            cnt_n    = CARGA;
            cambio_n = 1'b1;
          end else begin
            estado_n  = FIN;
            valido_n  = 1'b0;
            ocupado_n = 1'b0;
            fin_n     = 1'b1;
          end
        end
        FIN: begin
          estado_n = REPOSO;
        end
        default: begin
          estado_n = REPOSO;
        end
      endcase
    end
  end

  assign o_Sel     = sel;
  assign o_Valido  = valido;
  assign o_Cambio  = cambio;
  assign o_Ocupado = ocupado;
  assign o_Fin     = fin;

endmodule

// File: tb/tb_secuenciador_sel.sv
// Bench for secuenciador_sel. A reference model expands each sweep into its
// per-cycle output trace and queues it; a monitor compares every cycle's
// outputs against the queue head (or the idle pattern when the queue is empty).
module tb_secuenciador_sel;

  localparam int unsigned DW = 4;

  typedef struct packed {
    logic [1:0] sel;
    logic       valido;
    logic       cambio;
    logic       ocupado;
    logic       fin;
  } salida_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio, continuo, detener;
  logic [3:0] mascara;
  logic [1:0] sel;
  logic       valido, cambio, ocupado, fin;

  logic       inicio1, continuo1, detener1;
  logic [3:0] mascara1;
  logic [1:0] sel1;
  logic       valido1, cambio1, ocupado1, fin1;

  salida_t     esperado_q[$];
  logic [1:0]  ultimo_sel;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  secuenciador_sel #(.DWELL(DW), .DWELL_W(4)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Inicio(inicio), .i_Continuo(continuo),
    .i_Detener(detener), .i_Mascara(mascara), .o_Sel(sel), .o_Valido(valido),
    .o_Cambio(cambio), .o_Ocupado(ocupado), .o_Fin(fin)
  );

  secuenciador_sel #(.DWELL(1), .DWELL_W(2)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Inicio(inicio1), .i_Continuo(continuo1),
    .i_Detener(detener1), .i_Mascara(mascara1), .o_Sel(sel1), .o_Valido(valido1),
    .o_Cambio(cambio1), .o_Ocupado(ocupado1), .o_Fin(fin1)
  );

  // Behavioural Demx attached to the DWELL=1 sequencer.
  logic [3:0] datos[4];
  logic [3:0] salida_demx;
  initial begin
    datos[0] = 4'd5; datos[1] = 4'd2; datos[2] = 4'd3; datos[3] = 4'd4;
  end
  assign salida_demx = datos[sel1];

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", nombre, $time, act, req);
    end
  endtask

  // Expected trace of a sweep: enabled channels in ascending order, DWELL
  // cycles each; continuous mode cycles the list; 'corte' (if non-zero) is
  // the number of active cycles before an abort takes effect.
  function automatic void construir(input logic [3:0] m, input logic cont, input int unsigned corte);
    int unsigned canales[$];
    int unsigned n_esp;
    salida_t     e;
    for (int unsigned c = 0; c < 4; c++) if (m[c]) canales.push_back(c);
    n_esp = (cont || corte != 0) ? corte : canales.size() * DW;
    for (int unsigned n = 0; n < n_esp; n++) begin
      e.sel     = 2'(canales[(n / DW) % canales.size()]);
      e.valido  = 1'b1;
      e.cambio  = (n % DW) == 0;
      e.ocupado = 1'b1;
      e.fin     = 1'b0;
      esperado_q.push_back(e);
    end
    if (!cont && corte == 0) begin
      e.sel     = 2'(canales[canales.size() - 1]);
      e.valido  = 1'b0;
      e.cambio  = 1'b0;
      e.ocupado = 1'b0;
      e.fin     = 1'b1;
      esperado_q.push_back(e);
    end
  endfunction

  // Called at a negedge; returns at a negedge with the DUT idle.
  task automatic barrido(input logic [3:0] m, input logic cont, input int unsigned corte, input bit ruido);
    int unsigned activos;
    mascara  = m;
    continuo = cont;
    inicio   = 1'b1;
    detener  = 1'b0;
    construir(m, cont, corte);
    activos = (corte != 0) ? corte : $countones(m) * DW + 1;
    for (int unsigned i = 1; i <= activos; i++) begin
      @(negedge clk);
      if (ruido) begin
        inicio   = 1'($urandom);
        mascara  = 4'($urandom);
        continuo = 1'($urandom);
      end else begin
        inicio = 1'b0;
      end
      if (corte != 0 && i == corte) detener = 1'b1;
    end
    @(negedge clk);
    inicio  = 1'b0;
    detener = 1'b0;
    mascara = '0;
  endtask

  // Monitor: one comparison per cycle, #1 after the rising edge.
  salida_t act_m, exp_m;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      act_m = {sel, valido, cambio, ocupado, fin};
      if (esperado_q.size() > 0) begin
        exp_m      = esperado_q.pop_front();
        ultimo_sel = exp_m.sel;
      end else begin
        exp_m = '{sel: ultimo_sel, default: 1'b0};
      end
      checks++;
      if (act_m !== exp_m) begin
        errors++;
        $display("FAIL salida at %0t: got sel/val/cam/ocu/fin=%b required %b",
                 $time, act_m, exp_m);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [3:0]  m;
    logic        c;
    int unsigned k, corte;
    int unsigned exp_seq[4];
    exp_seq[0] = 5; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 4;

    rst = 1'b1;
    inicio = 1'b0; continuo = 1'b0; detener = 1'b0; mascara = '0;
    inicio1 = 1'b0; continuo1 = 1'b0; detener1 = 1'b0; mascara1 = '0;
    ultimo_sel = '0;
    repeat (2) @(negedge clk);
    chk("reset_out", {26'd0, sel, valido, cambio, ocupado, fin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    barrido(4'b1111, 1'b0, 0, 1'b0);
    barrido(4'b1010, 1'b0, 0, 1'b0);
    @(negedge clk);
    barrido(4'b1001, 1'b1, 10, 1'b0);
    // Zero mask and abort-with-start are both ignored while idle.
    inicio = 1'b1; mascara = '0; @(negedge clk);
    detener = 1'b1; mascara = 4'b1111; @(negedge clk);
    inicio = 1'b0; detener = 1'b0; mascara = '0;
    barrido(4'b1111, 1'b0, 0, 1'b1);
    barrido(4'b0100, 1'b1, 9, 1'b0);
    barrido(4'b1000, 1'b0, 0, 1'b1);

    repeat (30) begin
      m = 4'($urandom_range(1, 15));
      c = 1'($urandom);
      k = $countones(m);
      if (c) corte = $urandom_range(1, 3 * k * DW);
      else if ($urandom_range(0, 2) == 0) corte = $urandom_range(1, k * DW);
      else corte = 0;
      barrido(m, c, corte, 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        inicio = 1'($urandom); mascara = '0; detener = 1'b0;
        @(negedge clk);
      end
      inicio = 1'b0;
    end

    // Asynchronous reset between edges during a dwell.
    mascara = 4'b1111; continuo = 1'b0; inicio = 1'b1;
    construir(4'b1111, 1'b0, 0);
    @(negedge clk);
    inicio = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", {26'd0, sel, valido, cambio, ocupado, fin}, 32'd0);
    esperado_q.delete();
    ultimo_sel = '0;
    mascara = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    barrido(4'b1111, 1'b0, 0, 1'b0);

    // DWELL=1, continuous, all channels: one channel per cycle.
    mascara1 = 4'b1111; continuo1 = 1'b1; inicio1 = 1'b1;
    @(negedge clk);
    inicio1 = 1'b0;
    for (int unsigned j = 0; j < 9; j++) begin
      chk("d1_sel", {30'd0, sel1}, j % 4);
      chk("d1_cambio_valido", {30'd0, cambio1, valido1}, 32'd3);
      chk("d1_demx", {28'd0, salida_demx}, exp_seq[j % 4]);
      if (j == 8) detener1 = 1'b1;
      @(negedge clk);
    end
    detener1 = 1'b0;
    chk("d1_stop", {29'd0, valido1, ocupado1, fin1}, 32'd0);

    for (int unsigned w = 0; w < 60 && esperado_q.size() > 0; w++) @(negedge clk);
    chk("queue_drained", esperado_q.size(), 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
